// File: rtl/tensor_core_scheduler.sv
// Round-robin scheduler that shares one tensor core and its register file among N_REQ requesters.
// Define TC_SCHED_PERF_EN to add saturating matmul/timeout performance counter outputs.
module tensor_core_scheduler #(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [N_REQ-1:0]         req_valid_in,
  output logic [N_REQ-1:0]         req_ready_out,
  input  logic [2*N_REQ-1:0]       req_op_in,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr_in,
  input  logic [DATA_W*N_REQ-1:0]  req_data_in,
  output logic                     tc_write_enable_out,
  output logic [ADDR_W-1:0]        tc_write_address_out,
  output logic [DATA_W-1:0]        tc_write_data_out,
  output logic                     tc_clear_out,
  output logic                     tc_start_out,
  input  logic                     tc_done_in,
  output logic                     tc_bulk_write_enable_out,
  output logic                     busy_out,
  output logic                     done_valid_out,
  output logic [ID_W-1:0]          done_id_out,
  output logic                     done_error_out
`ifdef TC_SCHED_PERF_EN
  ,
  output logic [15:0]              perf_matmul_count_out,
  output logic [7:0]               perf_timeout_count_out
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_CLEAR, S_START, S_WAIT, S_COMMIT, S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_MATMUL = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_NOP    = 2'b11
  } op_e;

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                clear_q, clear_d;
  logic                start_q, start_d;
  logic                bulk_q, bulk_d;
  logic                busy_q, busy_d;
  logic                dv_q, dv_d;
  logic                err_q, err_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic                accept;
  op_e                 sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Rotating-priority search beginning at the requester after the last accepted one.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_q) + i) % N_REQ;
      if (!grant_found && req_valid_in[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Grants are withheld while reset is asserted so the ready vector is 0 during reset.
  assign accept   = grant_found && (state_q == S_IDLE) && reset_in;
  assign sel_op   = op_e'(req_op_in[2*int'(grant_id) +: 2]);
  assign sel_addr = req_addr_in[ADDR_W*int'(grant_id) +: ADDR_W];
  assign sel_data = req_data_in[DATA_W*int'(grant_id) +: DATA_W];

  always_comb begin
    req_ready_out = '0;
    if (accept) req_ready_out[grant_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (sel_op)
            OP_WRITE:  state_d = S_WRITE;
            OP_MATMUL: state_d = S_START;
            OP_CLEAR:  state_d = S_CLEAR;
            OP_NOP:    state_d = S_IDLE;
          endcase
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A done arriving on the final allowed cycle still commits.
        if (tc_done_in)                     state_d = S_COMMIT;
        else if (wait_cnt_q == TIMEOUT_VAL) state_d = S_ERROR;
      end
      S_WRITE, S_CLEAR, S_COMMIT, S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d       = accept ? ID_W'((int'(grant_id) + 1) % N_REQ) : rr_q;
    owner_d    = accept ? grant_id : owner_q;
    wait_cnt_d = 8'd0;
    if (state_d == S_WAIT)
      wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 8'd1 : 8'd1;

    // Strobes are decoded from the next state so each is a registered pulse for that state.
    we_d      = (state_d == S_WRITE);
    waddr_d   = we_d ? sel_addr : '0;
    wdata_d   = we_d ? sel_data : '0;
    clear_d   = (state_d == S_CLEAR);
    start_d   = (state_d == S_START);
    bulk_d    = (state_d == S_COMMIT);
    err_d     = (state_d == S_ERROR);
    dv_d      = bulk_d || err_d;
    done_id_d = dv_d ? owner_q : done_id_q;
    busy_d    = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      owner_q    <= '0;
      done_id_q  <= '0;
      wait_cnt_q <= 8'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      clear_q    <= 1'b0;
      start_q    <= 1'b0;
      bulk_q     <= 1'b0;
      busy_q     <= 1'b0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      done_id_q  <= done_id_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      clear_q    <= clear_d;
      start_q    <= start_d;
      bulk_q     <= bulk_d;
      busy_q     <= busy_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
    end
  end

  assign tc_write_enable_out      = we_q;
  assign tc_write_address_out     = waddr_q;
  assign tc_write_data_out        = wdata_q;
  assign tc_clear_out             = clear_q;
  assign tc_start_out             = start_q;
  assign tc_bulk_write_enable_out = bulk_q;
  assign busy_out                 = busy_q;
  assign done_valid_out           = dv_q;
  assign done_id_out              = done_id_q;
  assign done_error_out           = err_q;

`ifdef TC_SCHED_PERF_EN
  logic [15:0] perf_mm_q, perf_mm_d;
  logic [7:0]  perf_to_q, perf_to_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    perf_mm_d = perf_mm_q;
    perf_to_d = perf_to_q;
    if (state_d == S_COMMIT && perf_mm_q != 16'hFFFF) perf_mm_d = perf_mm_q + 16'd1;
    if (state_d == S_ERROR  && perf_to_q != 8'hFF)    perf_to_d = perf_to_q + 8'd1;
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      perf_mm_q <= 16'd0;
      perf_to_q <= 8'd0;
    end else begin
      perf_mm_q <= perf_mm_d;
      perf_to_q <= perf_to_d;
    end
  end

  assign perf_matmul_count_out  = perf_mm_q;
  assign perf_timeout_count_out = perf_to_q;
`endif

endmodule
